// File: rtl/cmd_dispatch_pkg.sv
// Shared definitions for the UART command dispatcher: target codes, prefix bytes,
// FSM states and payload-length / prefix-decode helpers.
package cmd_dispatch_pkg;

  typedef enum logic [1:0] {
    TGT_COLOUR   = 2'd0,
    TGT_TIMEBASE = 2'd1,
    TGT_GAIN     = 2'd2,
    TGT_NONE     = 2'd3
  } tgt_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ROUTE = 1'b1
  } state_e;

  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_T_UP = 8'h54;
  localparam logic [7:0] ASCII_T_LO = 8'h74;
  localparam logic [7:0] ASCII_G_UP = 8'h47;
  localparam logic [7:0] ASCII_G_LO = 8'h67;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;

  function automatic tgt_e decode_prefix(input logic [7:0] b);
    tgt_e t;
    case (b)
      ASCII_C_UP, ASCII_C_LO: t = TGT_COLOUR;
      ASCII_T_UP, ASCII_T_LO: t = TGT_TIMEBASE;
      ASCII_G_UP, ASCII_G_LO: t = TGT_GAIN;
      default:                t = TGT_NONE;
    endcase
    return t;
  endfunction

  function automatic logic [3:0] len_of(input tgt_e tgt, input int unsigned colour_len,
                                        input int unsigned timebase_len, input int unsigned gain_len);
    logic [3:0] len;
    case (tgt)
      TGT_COLOUR:   len = 4'(colour_len);
      TGT_TIMEBASE: len = 4'(timebase_len);
      TGT_GAIN:     len = 4'(gain_len);
      default:      len = '0;
    endcase
    return len;
  endfunction

  // TGT_NONE shifts the single bit out of range, giving an all-zero strobe.
  function automatic logic [2:0] tgt_onehot(input tgt_e tgt);
    return 3'(3'b001 << tgt);
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Loadable inactivity down-counter; expired is high once the count has reached zero.
module cmd_timeout_timer
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = W'(TIMEOUT_CYCLES);
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Routes prefixed UART commands to colour/timebase/gain blocks with ESC/timeout abort.
// Optional byte echo towards the UART transmitter is built when CMD_DISPATCH_ECHO_EN is defined.
module uart_cmd_dispatcher
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned COLOUR_LEN     = 3,
  parameter int unsigned TIMEBASE_LEN   = 2,
  parameter int unsigned GAIN_LEN       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_data,
  input  logic       uart_data_valid,
  output logic [7:0] tgt_data,
  output logic [2:0] tgt_valid,
  output logic [2:0] tgt_abort,
  output logic [1:0] active_target,
  output logic       busy,
  output logic       err_unknown
`ifdef CMD_DISPATCH_ECHO_EN
  ,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       echo_overrun
`endif
);

  state_e     state_q, state_d;
  tgt_e       tgt_q, tgt_d, pfx;
  logic [3:0] remain_q, remain_d;
  logic [7:0] data_q, data_d;
  logic [2:0] valid_q, valid_d;
  logic [2:0] abort_q, abort_d;
  logic       err_q, err_d;
  logic       tmr_load, tmr_tick, tmr_expired;

  cmd_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .tick   (tmr_tick),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    remain_d = remain_q;
    data_d   = data_q;
    valid_d  = '0;
    abort_d  = '0;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_tick = 1'b0;
    pfx      = decode_prefix(uart_data);
    unique case (state_q)
      ST_IDLE: begin
        if (uart_data_valid) begin
          if (pfx != TGT_NONE) begin
            tgt_d    = pfx;
            remain_d = len_of(pfx, COLOUR_LEN, TIMEBASE_LEN, GAIN_LEN);
            tmr_load = 1'b1;
            state_d  = ST_ROUTE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ROUTE: begin
        // An arriving byte takes precedence over a simultaneous timer expiry.
        if (uart_data_valid) begin
          if (uart_data == ASCII_ESC) begin
            abort_d = tgt_onehot(tgt_q);
            tgt_d   = TGT_NONE;
            state_d = ST_IDLE;
          end else begin
            data_d   = uart_data;
            valid_d  = tgt_onehot(tgt_q);
            remain_d = remain_q - 4'd1;
            tmr_load = 1'b1;
            if (remain_q == 4'd1) begin
              tgt_d   = TGT_NONE;
              state_d = ST_IDLE;
            end
          end
        end else if (tmr_expired) begin
          abort_d = tgt_onehot(tgt_q);
          tgt_d   = TGT_NONE;
          state_d = ST_IDLE;
        end else begin
          tmr_tick = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tgt_q    <= TGT_NONE;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      abort_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
    end
  end

  assign tgt_data      = data_q;
  assign tgt_valid     = valid_q;
  assign tgt_abort     = abort_q;
  assign active_target = tgt_q;
  assign busy          = (state_q == ST_ROUTE);
  assign err_unknown   = err_q;

`ifdef CMD_DISPATCH_ECHO_EN
  logic [7:0] txd_q, txd_d;
  logic       txv_q, txv_d;
  logic       ovr_q, ovr_d;

  // A new byte may reload the echo slot in the same cycle the old one is taken.
  always_comb begin
    txd_d = txd_q;
    txv_d = txv_q;
    ovr_d = ovr_q;
    if (uart_data_valid) begin
      if (txv_q && !tx_ready) begin
        ovr_d = 1'b1;
      end else begin
        txd_d = uart_data;
        txv_d = 1'b1;
      end
    end else if (txv_q && tx_ready) begin
      txv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txd_q <= '0;
      txv_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      txd_q <= txd_d;
      txv_q <= txv_d;
      ovr_q <= ovr_d;
    end
  end

  assign tx_data      = txd_q;
  assign tx_valid     = txv_q;
  assign echo_overrun = ovr_q;
`endif

endmodule
